// File: rtl/hub75_fb_arb.sv
// hub75_fb_arb - write-port arbiter and clear engine for the HUB75 framebuffer
// (16384 x 16-bit words, 4-bit nibble write mask).
//
// Shares the single framebuffer write port between a host requester and a DMA
// requester with two-way round-robin arbitration. The last-grant pointer
// resets to DMA, so the host wins the first tie.
//
// Optional feature macro: HUB75_FB_CLEAR_EN
//   defined   : clear engine present; a clr_start pulse fills all 16384 words
//               with clr_data (mask 4'hF), one write per cycle, and blocks
//               both requesters while it runs.
//   undefined : clr_start/clr_data ignored, clr_busy tied 0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   h_addr/h_data/h_mask  host write request, h_valid/h_ready handshake
//   d_addr/d_data/d_mask  DMA write request,  d_valid/d_ready handshake
//   clr_start, clr_data   clear start pulse and fill value
//   clr_busy              clear in progress
//   mem_wr_*              registered framebuffer write port
module hub75_fb_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] h_addr,
  input  logic [15:0] h_data,
  input  logic [3:0]  h_mask,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [13:0] d_addr,
  input  logic [15:0] d_data,
  input  logic [3:0]  d_mask,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic        clr_start,
  input  logic [15:0] clr_data,
  output logic        clr_busy,
  output logic [13:0] mem_wr_addr,
  output logic [15:0] mem_wr_data,
  output logic [3:0]  mem_wr_mask,
  output logic        mem_wr_ena
);

  logic [13:0] addr_q;
  logic [15:0] data_q;
  logic [3:0]  mask_q;
  logic        ena_q;
  logic        last_dma_q;  // 1: DMA was granted last
  logic        arb_ok;
  logic        gnt_h, gnt_d;

`ifdef HUB75_FB_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  state_t      state_q;
  logic [13:0] cnt_q;
  logic [15:0] fill_q;
  logic        busy_q;

  // A clr_start cycle takes priority over any pending request.
  assign arb_ok   = (state_q == S_IDLE) && !clr_start;
  assign clr_busy = busy_q;
`else
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_data};
  assign arb_ok     = 1'b1;
  assign clr_busy   = 1'b0;
`endif

  assign gnt_h   = arb_ok && h_valid && (!d_valid || last_dma_q);
  assign gnt_d   = arb_ok && d_valid && (!h_valid || !last_dma_q);
  assign h_ready = gnt_h;
  assign d_ready = gnt_d;

  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign mem_wr_mask = mask_q;
  assign mem_wr_ena  = ena_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      ena_q      <= 1'b0;
      last_dma_q <= 1'b1;
`ifdef HUB75_FB_CLEAR_EN
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fill_q     <= '0;
      busy_q     <= 1'b0;
`endif
    end else begin
      // Address/data/mask hold their last value when no write is issued.
      ena_q <= 1'b0;
      if (gnt_h) begin
        addr_q     <= h_addr;
        data_q     <= h_data;
        mask_q     <= h_mask;
        ena_q      <= 1'b1;
        last_dma_q <= 1'b0;
      end else if (gnt_d) begin
        addr_q     <= d_addr;
        data_q     <= d_data;
        mask_q     <= d_mask;
        ena_q      <= 1'b1;
        last_dma_q <= 1'b1;
      end
`ifdef HUB75_FB_CLEAR_EN
      // Grants are impossible in S_CLEAR, so the clear writes never collide
      // with the arbiter writes above.
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (clr_start) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            fill_q  <= clr_data;
          end
        end
        S_CLEAR: begin
          busy_q <= 1'b1;
          ena_q  <= 1'b1;
          addr_q <= cnt_q;
          data_q <= fill_q;
          mask_q <= 4'hF;
          cnt_q  <= cnt_q + 14'd1;
          // Leaving here lets requesters be granted on the very next edge,
          // while busy drops one edge later together with the last write.
          if (cnt_q == 14'h3FFF) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_hub75_fb_arb.sv
module tb_hub75_fb_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] h_addr = '0, d_addr = '0;
  logic [15:0] h_data = '0, d_data = '0, clr_data = '0;
  logic [3:0]  h_mask = '0, d_mask = '0;
  logic        h_valid = 1'b0, d_valid = 1'b0, clr_start = 1'b0;
  logic        h_ready, d_ready, clr_busy, mem_wr_ena;
  logic [13:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic [3:0]  mem_wr_mask;

  int n_cmp = 0;
  int n_bad = 0;

  logic [33:0] exp_q[$];  // {addr, data, mask}

  // reference model state
  logic        m_last_dma;
  logic        m_clr;
  logic [13:0] m_cnt;
  logic [15:0] m_fill;
  logic        m_busy;
  logic        h_took, d_took;

  hub75_fb_arb dut (
    .clk(clk), .rst(rst),
    .h_addr(h_addr), .h_data(h_data), .h_mask(h_mask), .h_valid(h_valid), .h_ready(h_ready),
    .d_addr(d_addr), .d_data(d_data), .d_mask(d_mask), .d_valid(d_valid), .d_ready(d_ready),
    .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .mem_wr_ena(mem_wr_ena)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every expected write must appear exactly one cycle after its grant.
  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_ena", 36'(mem_wr_ena), 36'(exp_q.size() != 0));
      if (mem_wr_ena && exp_q.size() != 0)
        chk("wr_word", 36'({mem_wr_addr, mem_wr_data, mem_wr_mask}), 36'(exp_q.pop_front()));
    end
  end

  task automatic model_reset();
    m_last_dma = 1'b1;
    m_clr      = 1'b0;
    m_cnt      = '0;
    m_fill     = '0;
    m_busy     = 1'b0;
    h_took     = 1'b0;
    d_took     = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: drive at negedge, check handshakes, predict writes.
  task automatic cycle(input logic hv, input logic dv, input logic cs);
    logic ok, eh, ed;
    @(negedge clk);
    if (h_took) begin
      h_addr = 14'($urandom); h_data = 16'($urandom); h_mask = 4'($urandom);
    end
    if (d_took) begin
      d_addr = 14'($urandom); d_data = 16'($urandom); d_mask = 4'($urandom);
    end
    h_valid = hv; d_valid = dv; clr_start = cs;
    #1;
    chk("clr_busy", 36'(clr_busy), 36'(m_busy));
`ifdef HUB75_FB_CLEAR_EN
    ok = !m_clr && !cs;
`else
    ok = 1'b1;
`endif
    eh = ok && hv && (!dv || m_last_dma);
    ed = ok && dv && (!hv || !m_last_dma);
    chk("h_ready", 36'(h_ready), 36'(eh));
    chk("d_ready", 36'(d_ready), 36'(ed));
    h_took = eh;
    d_took = ed;
    if (eh) begin exp_q.push_back({h_addr, h_data, h_mask}); m_last_dma = 1'b0; end
    if (ed) begin exp_q.push_back({d_addr, d_data, d_mask}); m_last_dma = 1'b1; end
`ifdef HUB75_FB_CLEAR_EN
    if (!m_clr) begin
      m_busy = 1'b0;
      if (cs) begin m_clr = 1'b1; m_cnt = '0; m_fill = clr_data; end
    end else begin
      m_busy = 1'b1;
      exp_q.push_back({m_cnt, m_fill, 4'hF});
      if (m_cnt == 14'h3FFF) m_clr = 1'b0;
      m_cnt = m_cnt + 14'd1;
    end
`endif
    @(posedge clk);
  endtask

  task automatic do_reset();
    h_valid = 1'b0; d_valid = 1'b0; clr_start = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    chk("rst_ena",  36'(mem_wr_ena),  36'(0));
    chk("rst_addr", 36'(mem_wr_addr), 36'(0));
    chk("rst_data", 36'(mem_wr_data), 36'(0));
    chk("rst_mask", 36'(mem_wr_mask), 36'(0));
    chk("rst_busy", 36'(clr_busy),    36'(0));
  endtask

  initial begin
    model_reset();
    do_reset();

    // host only, fixed values
    h_addr = 14'h0123; h_data = 16'hBEEF; h_mask = 4'h5;
    cycle(1, 0, 0);
    cycle(0, 0, 0);

    // both valid right after reset: host, DMA, host, DMA
    do_reset();
    d_addr = 14'h2000; d_data = 16'h1234; d_mask = 4'hA;
    repeat (4) cycle(1, 1, 0);
    cycle(0, 0, 0);

    // DMA alone for 3 cycles, then a tie goes to the host
    repeat (3) cycle(0, 1, 0);
    repeat (3) cycle(1, 1, 0);
    cycle(0, 0, 0);

    // randomized mix
    for (int i = 0; i < 40; i++) cycle(1'($urandom), 1'($urandom), 1'b0);
    cycle(0, 0, 0);

`ifdef HUB75_FB_CLEAR_EN
    // full clear with both requesters pending; a second start is ignored
    clr_data = 16'h0F0F;
    cycle(1, 1, 1);
    for (int i = 0; i < 17000 && m_clr; i++) begin
      clr_data = 16'($urandom);
      cycle(1, 1, (i == 500) ? 1'b1 : 1'b0);
    end
    chk("clr_done", 36'(m_clr), 36'(0));
    repeat (2) cycle(1, 1, 0);
    repeat (3) cycle(0, 0, 0);

    // reset in the middle of a clear
    clr_data = 16'h5A5A;
    cycle(1, 0, 1);
    for (int i = 0; i < 400 && !(m_clr && m_cnt == 14'h0101); i++) cycle(1, 0, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_ena",  36'(mem_wr_ena),  36'(0));
    chk("arst_addr", 36'(mem_wr_addr), 36'(0));
    chk("arst_data", 36'(mem_wr_data), 36'(0));
    chk("arst_mask", 36'(mem_wr_mask), 36'(0));
    chk("arst_busy", 36'(clr_busy),    36'(0));
    h_valid = 1'b0; d_valid = 1'b0; clr_start = 1'b0;
    model_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    h_addr = 14'h0042; h_data = 16'hCAFE; h_mask = 4'h3;
    cycle(1, 0, 0);
    repeat (5) cycle(0, 0, 0);
`else
    // clear engine absent: clr_start is ignored
    clr_data = 16'h0F0F;
    cycle(1, 0, 1);
    cycle(0, 1, 1);
    repeat (5) cycle(0, 0, 0);
`endif

    chk("scoreboard_empty", 36'(exp_q.size()), 36'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global safety net
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL timeout: simulation did not finish, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
